// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide sequencer producing HI/LO for mfhi/mflo.
// Radix-2 shift-add multiply or restoring divide on magnitudes, sign fixed on the last step.
module mult_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   r_p_hi;
  logic [WIDTH-1:0] r_p_lo;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH:0]   w_nx_hi;
  logic [WIDTH-1:0] w_nx_lo;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  // One iteration of the selected algorithm plus the signed final result
  always_comb begin
    w_abs_a = a[WIDTH-1] ? WIDTH'(0) - a : a;
    w_abs_b = b[WIDTH-1] ? WIDTH'(0) - b : b;
    w_add   = r_p_hi + {1'b0, r_mcand};
    w_sum   = r_p_lo[0] ? w_add : r_p_hi;
    w_shift = {r_p_hi[WIDTH-1:0], r_p_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_mcand});
    w_diff  = w_shift - {1'b0, r_mcand};
    if (r_op) begin
      w_nx_hi = w_ge ? w_diff : w_shift;
      w_nx_lo = {r_p_lo[WIDTH-2:0], w_ge};
    end else begin
      w_nx_hi = {1'b0, w_sum[WIDTH:1]};
      w_nx_lo = {w_sum[0], r_p_lo[WIDTH-1:1]};
    end
    w_prod     = {w_nx_hi[WIDTH-1:0], w_nx_lo};
    w_prod_fix = r_neg_res ? PW'(0) - w_prod : w_prod;
    w_q        = r_neg_res ? WIDTH'(0) - w_nx_lo : w_nx_lo;
    w_r        = r_neg_rem ? WIDTH'(0) - w_nx_hi[WIDTH-1:0] : w_nx_hi[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_mcand   <= '0;
      r_p_hi    <= '0;
      r_p_lo    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_cnt     <= '0;
            r_neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_rem <= a[WIDTH-1];
            r_p_hi    <= '0;
            busy      <= 1'b1;
            if (op) begin
              r_mcand <= w_abs_b;
              r_p_lo  <= w_abs_a;
            end else begin
              r_mcand <= w_abs_a;
              r_p_lo  <= w_abs_b;
            end
            // Divide by zero skips the iterations and leaves hi/lo untouched
            if (op && (b == '0)) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_p_hi <= w_nx_hi;
          r_p_lo <= w_nx_lo;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            if (r_op) begin
              hi <= w_r;
              lo <= w_q;
            end else begin
              hi <= w_prod_fix[PW-1:WIDTH];
              lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          div_zero <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          div_zero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed corners plus random ops against a 64-bit arithmetic model.
module tb_mult_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned ncmp;
  int unsigned nerr;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference arithmetic in 64-bit signed integers; div by zero keeps prior hi/lo
  task automatic model(input logic o, input logic [31:0] xa, input logic [31:0] xb,
                       output logic [31:0] nh, output logic [31:0] nl, output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    dz = 1'b0;
    nh = exp_hi;
    nl = exp_lo;
    if (!o) begin
      p  = sa * sb;
      nh = p[63:32];
      nl = p[31:0];
    end else if (xb == 32'd0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      nh = r[31:0];
      nl = q[31:0];
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dz"}, 32'(div_zero), 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  // Issue one op and check every cycle up to and just past done
  task automatic run_op(input logic o, input logic [31:0] xa, input logic [31:0] xb, input bit inj);
    logic [31:0] nh, nl;
    logic        dz;
    int          lat;
    model(o, xa, xb, nh, nl, dz);
    lat = dz ? 1 : 33;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), 32'(k == lat));
      check("div_zero", 32'(div_zero), 32'(k == lat && dz));
      if (k == lat) begin
        exp_hi = nh;
        exp_lo = nl;
      end
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
      start = inj && (k == 5 || k == 33);
      if (start) begin
        op = 1'($urandom_range(0, 1));
        a  = $urandom;
        b  = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_idle("after");
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        ro;
    ncmp = 0; nerr = 0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    check("mul7_hi", hi, 32'hFFFF_FFFF);
    check("mul7_lo", lo, 32'hFFFF_FFEB);

    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    check("divm7_lo", lo, 32'hFFFF_FFFD);
    check("divm7_hi", hi, 32'hFFFF_FFFF);
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
    check("div7_lo", lo, 32'hFFFF_FFFD);
    check("div7_hi", hi, 32'h0000_0001);

    run_op(1'b0, 32'h0000_0006, 32'h2AAA_AAAB, 1'b0);
    check("pre_dz_hi", hi, 32'h0000_0001);
    check("pre_dz_lo", lo, 32'h0000_0002);
    run_op(1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0);
    check("dz_hi", hi, 32'h0000_0001);
    check("dz_lo", lo, 32'h0000_0002);

    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("minsq_hi", hi, 32'h4000_0000);
    check("minsq_lo", lo, 32'h0000_0000);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);

    run_op(1'b0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
    @(negedge clk);
    check_idle("inj_gap");

    // Abort a divide with reset mid-flight
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hFFFF_FF9C; b = 32'h0000_0007;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    #1;
    check_idle("rst_t10");
    @(negedge clk);
    check_idle("rst_t11");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_idle("rst_after");
    end
    run_op(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0);
    check("m34_hi", hi, 32'h0000_0000);
    check("m34_lo", lo, 32'h0000_000C);

    for (int i = 0; i < 14; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) rb = 32'($signed(16'($urandom)));
      if (i % 5 == 4) rb = 32'd0;
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Iterative signed multiply/divide sequencer for the multicycle CPU.
- The main control unit pulses start when it decodes mult or div, then waits in a wait state until done.
- The block runs a radix-2 shift-add multiplier or a restoring divider for WIDTH iterations and drives the HI/LO values that mfhi/mflo read.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- start  input  1  request pulse, sampled only in IDLE.
- op  input  1  0 = signed mult, 1 = signed div; sampled with start.
- a  input  WIDTH  multiplicand / dividend; sampled with start.
- b  input  WIDTH  multiplier / divisor; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  high with done when a div had b == 0.
- hi  output  WIDTH  mult: product[2W-1:W]; div: remainder.
- lo  output  WIDTH  mult: product[W-1:0]; div: quotient.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - busy, done, div_zero, hi, lo, iteration counter and internal registers all clear to 0.
  - A reset asserted mid-operation aborts it; no done is produced.
- States: IDLE, RUN, DONE. 2-bit encoding; the counter is log2(WIDTH)+1 bits.
- IDLE:
  - start=1 at edge T latches a, b and op, and clears the counter.
  - Next state is RUN, except for op=1 with b==0, which goes to DONE (see division by zero).
- RUN:
  - One iteration per cycle, counter 0..WIDTH-1.
  - After the WIDTH-1 iteration the state goes to DONE.
  - The iteration cycles are T+1..T+WIDTH.
- DONE:
  - Lasts exactly one cycle (T+WIDTH+1): done=1, busy=1.
  - hi/lo are updated at the edge entering DONE and are valid during the DONE cycle.
  - Next state is IDLE. busy drops and hi/lo hold until the next accepted operation completes.
- Latency: start at edge T -> done high in cycle T+WIDTH+1, i.e. T+33 for WIDTH=32.
- start is ignored while busy=1, including during DONE. Back-to-back starts are therefore spaced by at least WIDTH+2 cycles.
- Mult arithmetic:
  - Signed two's complement, full 2*WIDTH-bit product.
  - The implementation may use magnitudes with a final sign fix, or Booth recoding, as long as the result is exact.
- Div arithmetic:
  - Signed; quotient truncates toward zero.
  - The remainder takes the sign of the dividend and satisfies a = q*b + r with |r| < |b|.
  - Computed as a restoring divide on magnitudes, with the sign fix applied in the final RUN cycle.
- Overflow case: a = most-negative, b = -1 gives lo = most-negative (wraps) and hi = 0; no flag.
- Division by zero:
  - IDLE -> DONE directly, so done appears in cycle T+1.
  - div_zero=1 for that cycle only.
  - hi/lo keep their previous values.
- div_zero is 0 in every cycle except that DONE cycle.
- hi/lo never change outside the edge entering DONE, and never show intermediate iteration values.

Test Plan:
- Reset, then mult 7 x -3 (0x00000007, 0xFFFFFFFD) -> done only in cycle T+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high T+1..T+33.
- div -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then div 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001.
- After a mult leaves hi=0x1, lo=0x2, div 5 / 0 -> done and div_zero high in T+1 only; hi=0x1, lo=0x2 unchanged; busy low at T+2.
- mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start pulsed at T+5 and T+33 during a mult -> both ignored; exactly one done; hi/lo match the first operands.
- reset low at T+10 of a div, released at T+12, new mult 3 x 4 -> no done from the aborted div; outputs 0 during reset; result hi=0, lo=12 at the new T'+33.
